// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake states, memory arbiter FSM states, bus word type.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // RAM handshake reported by the system RAM each cycle.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Memory arbiter grant FSM.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// memory_arbiter: puts instruction-fetch and data-access requests onto one single-ported RAM.
// Data requests normally win. A data-streak counter forces an instruction grant once DSTREAK
// data grants have gone by while an instruction fetch was waiting.
//
// Ports:
//   CLK, nRST          clock, async active-low reset
//   iREN, iaddr        instruction read request / address
//   iload, iwait       instruction data (ramload) / not-complete
//   dREN, dWEN         data read / write request
//   daddr, dstore      data address / write data
//   dload, dwait       data returned (ramload) / not-complete
//   ramREN, ramWEN     RAM strobes
//   ramaddr, ramstore  RAM address / write data
//   ramload, ramstate  RAM read data / handshake state
//   memerr             sticky error (RAM ERROR or grant timeout)
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned DSTREAK = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        memerr
);

    localparam int unsigned SW = $clog2(DSTREAK + 1);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t    state_q, state_d;
    logic [SW-1:0] dstreak_q, dstreak_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic          memerr_q, memerr_d;

    ramstate_t rs;
    logic      dreq;
    logic      starve;
    logic      done;
    logic      fault;

    assign rs     = ramstate_t'(ramstate);
    assign dreq   = dREN | dWEN;
    assign starve = iREN && (dstreak_q == SW'(DSTREAK));
    assign done   = (rs == ACCESS);
    assign fault  = (rs == ERROR) || (timeout_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        dstreak_d = dstreak_q;
        memerr_d  = memerr_q;

        unique case (state_q)
            IDLE: begin
                if (!iREN) begin
                    dstreak_d = '0;
                end
                if (dreq && !starve) begin
                    state_d = DGRANT;
                end else if (iREN) begin
                    state_d = IGRANT;
                end
            end
            DGRANT: begin
                // A dropped request is abandoned silently; completion beats fault.
                if (!dreq) begin
                    state_d = IDLE;
                end else if (done) begin
                    state_d = IDLE;
                    if (iREN && (dstreak_q != SW'(DSTREAK))) begin
                        dstreak_d = dstreak_q + 1'b1;
                    end
                end else if (fault) begin
                    state_d  = IDLE;
                    memerr_d = 1'b1;
                end
            end
            IGRANT: begin
                if (!iREN) begin
                    state_d = IDLE;
                end else if (done) begin
                    state_d   = IDLE;
                    dstreak_d = '0;
                end else if (fault) begin
                    state_d  = IDLE;
                    memerr_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Counts cycles spent in the current grant; restarts on every state change.
        if (state_d != state_q) begin
            timeout_d = '0;
        end else if (state_q != IDLE) begin
            timeout_d = timeout_q + 1'b1;
        end else begin
            timeout_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            dstreak_q <= '0;
            timeout_q <= '0;
            memerr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dstreak_q <= dstreak_d;
            timeout_q <= timeout_d;
            memerr_q  <= memerr_d;
        end
    end

    // RAM side is combinational from the registered grant, so it goes quiet in IDLE and on reset.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = iREN;
        dwait    = dreq;

        unique case (state_q)
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (dreq && done) begin
                    dwait = 1'b0;
                end
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (iREN && done) begin
                    iwait = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    assign iload  = ramload;
    assign dload  = ramload;
    assign memerr = memerr_q;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        memerr;

    int nvec;
    int nmis;

    memory_arbiter #(
        .DSTREAK(4),
        .TIMEOUT(64)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .memerr   (memerr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked 1 time unit later.
    task automatic tick();
        @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] streak;
        logic       exp_i;
        nvec = 0;
        nmis = 0;
        nRST     = 1'b0;
        iREN     = 1'b0;
        iaddr    = 32'h0000_0100;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = FREE;

        // Reset state.
        #2;
        chk("rst_state", dut.state_q, IDLE);
        chk("rst_ramren", ramREN, 1'b0);
        chk("rst_ramwen", ramWEN, 1'b0);
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_ramstore", ramstore, 32'h0);
        chk("rst_memerr", memerr, 1'b0);
        chk("rst_dstreak", dut.dstreak_q, 32'd0);
        chk("rst_iwait_lo", iwait, 1'b0);
        iREN = 1'b1;
        #1;
        chk("rst_iwait_hi", iwait, 1'b1);
        iREN = 1'b0;
        tick();
        nRST = 1'b1;

        // Single data read.
        tick();
        dREN = 1'b1; daddr = 32'h40;
        #1;
        chk("rd_idle_ramren", ramREN, 1'b0);
        chk("rd_idle_dwait", dwait, 1'b1);
        tick();
        ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
        #1;
        chk("rd_state", dut.state_q, DGRANT);
        chk("rd_ramren", ramREN, 1'b1);
        chk("rd_ramaddr", ramaddr, 32'h40);
        chk("rd_dwait", dwait, 1'b0);
        chk("rd_dload", dload, 32'hDEAD_BEEF);
        chk("rd_iload", iload, 32'hDEAD_BEEF);
        tick();
        dREN = 1'b0; ramstate = FREE;
        #1;
        chk("rd_done_state", dut.state_q, IDLE);

        // Conflict: write wins, instruction follows.
        tick();
        iREN = 1'b1; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234;
        tick();
        ramstate = ACCESS;
        #1;
        chk("cf_state_d", dut.state_q, DGRANT);
        chk("cf_ramwen", ramWEN, 1'b1);
        chk("cf_ramren", ramREN, 1'b0);
        chk("cf_ramstore", ramstore, 32'h1234);
        chk("cf_ramaddr", ramaddr, 32'h80);
        chk("cf_iwait", iwait, 1'b1);
        chk("cf_dwait", dwait, 1'b0);
        tick();
        dWEN = 1'b0;
        #1;
        chk("cf_idle", dut.state_q, IDLE);
        chk("cf_streak1", dut.dstreak_q, 32'd1);
        tick();
        #1;
        chk("cf_state_i", dut.state_q, IGRANT);
        chk("cf_iaddr", ramaddr, 32'h100);
        chk("cf_iren", ramREN, 1'b1);
        chk("cf_iwait_done", iwait, 1'b0);
        tick();
        iREN = 1'b0; ramstate = FREE;
        #1;
        chk("cf_streak0", dut.dstreak_q, 32'd0);
        tick();

        // Starvation: four data grants then one instruction grant.
        iREN = 1'b1; dREN = 1'b1; daddr = 32'h200; ramstate = ACCESS;
        streak = 3'd0;
        for (int t = 0; t < 10; t++) begin
            exp_i = (streak == 3'd4);
            tick();
            #1;
            chk($sformatf("sv_grant%0d", t), dut.state_q, exp_i ? IGRANT : DGRANT);
            streak = exp_i ? 3'd0 : streak + 3'd1;
            tick();
            #1;
            chk($sformatf("sv_streak%0d", t), dut.dstreak_q, {29'd0, streak});
        end
        iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
        tick();

        // RAM busy for three cycles, then ACCESS.
        dREN = 1'b1; daddr = 32'h44;
        for (int k = 0; k < 3; k++) begin
            tick();
            ramstate = BUSY;
            #1;
            chk($sformatf("bz_state%0d", k), dut.state_q, DGRANT);
            chk($sformatf("bz_dwait%0d", k), dwait, 1'b1);
        end
        tick();
        ramstate = ACCESS;
        #1;
        chk("bz_dwait_done", dwait, 1'b0);
        tick();
        dREN = 1'b0; ramstate = FREE;
        #1;
        chk("bz_idle", dut.state_q, IDLE);
        tick();
        #1;
        chk("bz_no_extra", ramREN, 1'b0);

        // ERROR during an instruction grant.
        iREN = 1'b1;
        tick();
        ramstate = ERROR;
        #1;
        chk("er_state", dut.state_q, IGRANT);
        chk("er_memerr0", memerr, 1'b0);
        chk("er_iwait", iwait, 1'b1);
        tick();
        ramstate = FREE;
        #1;
        chk("er_idle", dut.state_q, IDLE);
        chk("er_memerr1", memerr, 1'b1);
        chk("er_iwait_hold", iwait, 1'b1);
        iREN = 1'b0;
        tick();
        tick();
        #1;
        chk("er_sticky", memerr, 1'b1);

        // Reset pulse during a data write grant.
        dWEN = 1'b1; daddr = 32'h88; dstore = 32'h55;
        tick();
        ramstate = BUSY;
        #1;
        chk("rs_ramwen_pre", ramWEN, 1'b1);
        nRST = 1'b0;
        #1;
        chk("rs_ramwen", ramWEN, 1'b0);
        chk("rs_state", dut.state_q, IDLE);
        dWEN = 1'b0; ramstate = FREE;
        tick();
        nRST = 1'b1;
        #1;
        chk("rs_state_rel", dut.state_q, IDLE);
        chk("rs_memerr", memerr, 1'b0);

        // Data request dropped mid-grant.
        tick();
        dREN = 1'b1; daddr = 32'h90;
        tick();
        ramstate = BUSY;
        #1;
        chk("dp_state", dut.state_q, DGRANT);
        tick();
        dREN = 1'b0;
        #1;
        chk("dp_dwait", dwait, 1'b0);
        tick();
        ramstate = FREE;
        #1;
        chk("dp_idle", dut.state_q, IDLE);
        chk("dp_memerr", memerr, 1'b0);

        // BUSY held through the whole timeout window.
        iREN = 1'b1; ramstate = BUSY;
        for (int k = 1; k <= 64; k++) begin
            tick();
            #1;
            if (k == 1 || k == 64) begin
                chk($sformatf("to_state%0d", k), dut.state_q, IGRANT);
                chk($sformatf("to_memerr%0d", k), memerr, 1'b0);
            end
        end
        tick();
        #1;
        chk("to_idle", dut.state_q, IDLE);
        chk("to_memerr", memerr, 1'b1);
        chk("to_iwait", iwait, 1'b1);
        iREN = 1'b0; ramstate = FREE;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
